// File: rtl/aes128_enc_core_pkg.sv
// rtl/aes128_enc_core_pkg.sv - AES-128 FSM states, S-box, round constants and state-transform helpers
package aes128_enc_core_pkg;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    // One 16-byte row of the FIPS-197 S-box per high nibble; the low nibble selects the byte.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        logic [127:0] sh;
        case (b[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        sh = row >> {~b[3:0], 3'b000};
        return sh[7:0];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // State byte r+4c sits at bits [127-8(r+4c) -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    function automatic logic [127:0] byte_rev(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = s[127-8*i -: 8];
        return o;
    endfunction

endpackage

// File: rtl/aes128_enc_core_if.sv
// rtl/aes128_enc_core_if.sv - plaintext in / ciphertext out bundle; key ports exist only with AES_KEY_LOAD_EN
interface aes128_enc_core_if;
    logic [127:0] data128;
    logic         data128_en;
    logic         in_ready;
    logic [127:0] ct_data;
    logic         ct_valid;
    logic         busy;
    logic         drop_err;
`ifdef AES_KEY_LOAD_EN
    logic [127:0] key_in;
    logic         key_load;

    modport master (output data128, data128_en, key_in, key_load,
                    input  in_ready, ct_data, ct_valid, busy, drop_err);
    modport slave  (input  data128, data128_en, key_in, key_load,
                    output in_ready, ct_data, ct_valid, busy, drop_err);
`else
    modport master (output data128, data128_en,
                    input  in_ready, ct_data, ct_valid, busy, drop_err);
    modport slave  (input  data128, data128_en,
                    output in_ready, ct_data, ct_valid, busy, drop_err);
`endif
endinterface

// File: rtl/aes128_enc_core_key_round.sv
// rtl/aes128_enc_core_key_round.sv - one combinational AES-128 key-expansion step
module aes128_enc_core_key_round
    import aes128_enc_core_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [7:0]   round_const,
    output logic [127:0] next_key
);
    logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key;
    // SubWord(RotWord(w3)) with the round constant folded into the leading byte
    assign temp = {sbox(w3[23:16]) ^ round_const, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_enc_core.sv
// rtl/aes128_enc_core.sv - iterative AES-128 encryptor, one round per clock; runtime key load under AES_KEY_LOAD_EN
module aes128_enc_core
    import aes128_enc_core_pkg::*;
#(
    parameter logic [127:0] KEY        = 128'h2b7e151628aed2a6abf7158809cf4f3c,
    parameter int           BYTE_ORDER = 0
) (
    input logic              sclk,
    input logic              rst,
    aes128_enc_core_if.slave bus
);
    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, rk_q, ct_q;
    logic [3:0]   round_q;
    logic         ct_valid_q, drop_q;
    logic         in_ready, busy, accept, last;
    logic [127:0] din, key0, next_rk, sb_sr;
    logic [7:0]   rc;

    assign last    = (round_q == LAST_ROUND);
    assign accept  = bus.data128_en & in_ready;
    assign din     = (BYTE_ORDER != 0) ? byte_rev(bus.data128) : bus.data128;
    assign sb_sr   = shift_rows(sub_bytes(state_q));
    assign rc      = rcon(round_q);

    aes128_enc_core_key_round u_key_round (
        .prev_key    (rk_q),
        .round_const (rc),
        .next_key    (next_rk)
    );

`ifdef AES_KEY_LOAD_EN
    logic [127:0] key_q, pend_key_q;
    logic         pend_q;

    // A load seen while rounds are running waits for the block boundary so the active block keeps its key.
    assign key0 = bus.key_load ? bus.key_in : (pend_q ? pend_key_q : key_q);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            key_q      <= KEY;
            pend_key_q <= '0;
            pend_q     <= 1'b0;
        end else if (in_ready) begin
            key_q  <= key0;
            pend_q <= 1'b0;
        end else if (bus.key_load) begin
            pend_key_q <= bus.key_in;
            pend_q     <= 1'b1;
        end
    end
`else
    assign key0 = KEY;
`endif

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) fsm_q <= ST_IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d    = fsm_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.data128_en) fsm_d = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last) begin
                    in_ready = 1'b1;
                    fsm_d    = bus.data128_en ? ST_RUN : ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q    <= '0;
            rk_q       <= '0;
            ct_q       <= '0;
            round_q    <= '0;
            ct_valid_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            ct_valid_q <= 1'b0;
            if (bus.data128_en && !in_ready) drop_q <= 1'b1;
            if (fsm_q == ST_RUN) begin
                if (last) begin
                    ct_q       <= (BYTE_ORDER != 0) ? byte_rev(sb_sr ^ next_rk) : (sb_sr ^ next_rk);
                    ct_valid_q <= 1'b1;
                    round_q    <= '0;
                end else begin
                    state_q <= mix_columns(sb_sr) ^ next_rk;
                    rk_q    <= next_rk;
                    round_q <= round_q + 4'd1;
                end
            end
            // A block accepted on the final round edge overrides the bookkeeping above.
            if (accept) begin
                state_q <= din ^ key0;
                rk_q    <= key0;
                round_q <= 4'd1;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.busy     = busy;
    assign bus.ct_data  = ct_q;
    assign bus.ct_valid = ct_valid_q;
    assign bus.drop_err = drop_q;

endmodule

// File: tb/tb_aes128_enc_core.sv
// tb/tb_aes128_enc_core.sv - randomized self-checking bench for aes128_enc_core against a byte-level AES model
module tb_aes128_enc_core;

    localparam logic [127:0] DEF_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef struct {
        int           cyc;
        logic [127:0] ct;
    } pulse_t;

    logic   sclk = 1'b0;
    logic   rst  = 1'b1;
    int     cyc  = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    logic   prev_valid = 1'b0;
    pulse_t pq[$];
    logic [7:0] sb [256];

    aes128_enc_core_if bus ();

    aes128_enc_core dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge sclk) begin
        if (bus.ct_valid) begin
            check("ct_valid_single_cycle", 128'(prev_valid), 128'd0);
            pq.push_back('{cyc, bus.ct_data});
        end
        prev_valid = bus.ct_valid;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box built from the GF(2^8) inverse and the affine map, not from a table.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp[31:24] ^= rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
                    s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
                for (int r = 0; r < 4; r++) s[r][c] ^= w[4*rnd+c][31-8*r -: 8];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[127-8*(r+4*c) -: 8] = s[r][c];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives a block for exactly one sampling edge; c0 is the cycle number of that edge.
    task automatic offer(input logic [127:0] pt, output int c0);
        @(posedge sclk); #1;
        bus.data128    = pt;
        bus.data128_en = 1'b1;
        @(posedge sclk); #1;
        c0 = cyc;
        bus.data128_en = 1'b0;
    endtask

    task automatic expect_ct(input string tag, input logic [127:0] exp, input int exp_cyc);
        pulse_t p;
        while (pq.size() == 0 && cyc <= exp_cyc + 4) begin
            @(negedge sclk); #1;
        end
        if (pq.size() == 0) begin
            check({tag, "_timeout"}, 128'd0, 128'd1);
        end else begin
            p = pq.pop_front();
            check({tag, "_ct"}, p.ct, exp);
            check({tag, "_latency"}, 128'(p.cyc), 128'(exp_cyc));
        end
    endtask

    task automatic do_reset();
        @(posedge sclk); #1;
        rst = 1'b1;
        repeat (2) @(posedge sclk);
        #1 rst = 1'b0;
    endtask

`ifdef AES_KEY_LOAD_EN
    task automatic pulse_key(input logic [127:0] k);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        @(posedge sclk); #1;
        bus.key_load = 1'b0;
    endtask
`endif

    initial begin
        logic [127:0] pt, pt2, exp;
        int c0, c1;

        bus.data128    = '0;
        bus.data128_en = 1'b0;
`ifdef AES_KEY_LOAD_EN
        bus.key_in   = '0;
        bus.key_load = 1'b0;
`endif
        build_sbox();
        #2;
        check("rst_ct_data",  bus.ct_data, 128'd0);
        check("rst_ct_valid", 128'(bus.ct_valid), 128'd0);
        check("rst_busy",     128'(bus.busy), 128'd0);
        check("rst_drop_err", 128'(bus.drop_err), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        repeat (2) @(posedge sclk);
        #1 rst = 1'b0;

        check("model_fips_b", aes_ref(DEF_KEY, 128'h3243f6a8885a308d313198a2e0370734),
              128'h3925841d02dc09fbdc118597196a0b32);
        offer(128'h3243f6a8885a308d313198a2e0370734, c0);
        @(negedge sclk);
        check("run_busy",     128'(bus.busy), 128'd1);
        check("run_in_ready", 128'(bus.in_ready), 128'd0);
        expect_ct("fips_b", 128'h3925841d02dc09fbdc118597196a0b32, c0 + 10);
        @(negedge sclk);
        check("idle_busy", 128'(bus.busy), 128'd0);

        for (int i = 0; i < 6; i++) begin
            pt = rand128();
            offer(pt, c0);
            expect_ct($sformatf("rand%0d", i), aes_ref(DEF_KEY, pt), c0 + 10);
            repeat ($urandom_range(0, 3)) @(posedge sclk);
        end

        pt  = rand128();
        pt2 = rand128();
        offer(pt, c0);
        repeat (8) @(posedge sclk);
        offer(pt2, c1);
        check("b2b_accept_edge", 128'(c1), 128'(c0 + 10));
        expect_ct("b2b_first",  aes_ref(DEF_KEY, pt),  c0 + 10);
        expect_ct("b2b_second", aes_ref(DEF_KEY, pt2), c0 + 20);
        check("b2b_drop_err", 128'(bus.drop_err), 128'd0);

        pt  = rand128();
        pt2 = rand128();
        offer(pt, c0);
        repeat (3) @(posedge sclk);
        offer(pt2, c1);
        @(negedge sclk);
        check("drop_err_set", 128'(bus.drop_err), 128'd1);
        expect_ct("drop_first", aes_ref(DEF_KEY, pt), c0 + 10);
        repeat (14) @(posedge sclk);
        check("drop_no_extra", 128'(pq.size()), 128'd0);
        check("drop_err_sticky", 128'(bus.drop_err), 128'd1);
        do_reset();
        check("drop_err_cleared", 128'(bus.drop_err), 128'd0);

        offer(rand128(), c0);
        repeat (6) @(posedge sclk);
        #1 rst = 1'b1;
        #1;
        check("abort_ct_data",  bus.ct_data, 128'd0);
        check("abort_busy",     128'(bus.busy), 128'd0);
        check("abort_in_ready", 128'(bus.in_ready), 128'd1);
        repeat (3) @(posedge sclk);
        #1 rst = 1'b0;
        repeat (12) @(posedge sclk);
        check("abort_no_ct_valid", 128'(pq.size()), 128'd0);
        pt = rand128();
        offer(pt, c0);
        expect_ct("after_abort", aes_ref(DEF_KEY, pt), c0 + 10);

`ifdef AES_KEY_LOAD_EN
        begin
            logic [127:0] k1, k2;
            k1 = 128'h000102030405060708090a0b0c0d0e0f;
            @(posedge sclk); #1;
            bus.key_in     = k1;
            bus.key_load   = 1'b1;
            bus.data128    = 128'h00112233445566778899aabbccddeeff;
            bus.data128_en = 1'b1;
            @(posedge sclk); #1;
            c0 = cyc;
            bus.key_load   = 1'b0;
            bus.data128_en = 1'b0;
            expect_ct("fips_c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, c0 + 10);

            k2  = rand128();
            pt  = rand128();
            pt2 = rand128();
            offer(pt, c0);
            repeat (2) @(posedge sclk);
            #1 pulse_key(k2);
            expect_ct("keyrun_old", aes_ref(k1, pt), c0 + 10);
            offer(pt2, c1);
            expect_ct("keyrun_new", aes_ref(k2, pt2), c1 + 10);
        end
`endif

        repeat (3) @(posedge sclk);
        check("final_no_extra", 128'(pq.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
